// File: rtl/maint_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maint_pkg
//  Description : Shared widths, limits and default intervals for the
//                maintenance request path.
//  Revision    : 1.0 - initial release
// ============================================================================
package maint_pkg;

    localparam int TIMER_WIDTH  = 28;
    localparam int MAX_PEND_REF = 8;
    localparam int PEND_WIDTH   = 4;

    localparam longint unsigned CLK_FREQ_MHZ = 400;
    localparam longint unsigned DEF_TREFI_NS = 7_800;
    localparam longint unsigned DEF_TZQI_NS  = 128_000_000;
    localparam longint unsigned DEF_TPRD_NS  = 1_000_000;

    // Rounds up so a derived interval never undershoots the DRAM requirement.
    function automatic logic [TIMER_WIDTH-1:0] ns_to_cycles(input longint unsigned ns);
        longint unsigned cyc;
        cyc = (ns * CLK_FREQ_MHZ + 64'd999) / 64'd1000;
        return cyc[TIMER_WIDTH-1:0];
    endfunction

    localparam logic [TIMER_WIDTH-1:0] DEF_TREFI = ns_to_cycles(DEF_TREFI_NS);
    localparam logic [TIMER_WIDTH-1:0] DEF_TZQI  = ns_to_cycles(DEF_TZQI_NS);
    localparam logic [TIMER_WIDTH-1:0] DEF_TPRD  = ns_to_cycles(DEF_TPRD_NS);

    typedef enum logic [1:0] {
        REF_HOLD = 2'd0,
        REF_INC  = 2'd1,
        REF_DEC  = 2'd2,
        REF_CLR  = 2'd3
    } ref_op_e;

endpackage
`default_nettype wire

// File: rtl/maint_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module      : maint_interval_timer
//  Description : Programmable down-counter issuing one tick every interval_i
//                cycles while enabled with a nonzero interval.
//  Revision    : 1.0 - initial release
// ============================================================================
module maint_interval_timer #(
    parameter int TIMER_WIDTH = maint_pkg::TIMER_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic [TIMER_WIDTH-1:0] interval_i,
    output logic                   tick_o
);

    logic [TIMER_WIDTH-1:0] cnt_q;
    logic [TIMER_WIDTH-1:0] cnt_d;
    logic                   w_run;

    assign w_run = en_i && (interval_i != '0);

    always_comb begin
        cnt_d  = cnt_q - TIMER_WIDTH'(1);
        tick_o = 1'b0;
        if (!w_run) begin
            cnt_d = interval_i;
        end else if (cnt_q == TIMER_WIDTH'(1)) begin
            tick_o = 1'b1;
            cnt_d  = interval_i;
        end else if (cnt_q == '0) begin
            // Left over from a zero interval: restart cleanly instead of wrapping.
            cnt_d = interval_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= interval_i;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/maint_req_gen.sv
`default_nettype none
// ============================================================================
//  Module      : maint_req_gen
//  Description : Periodic auto-refresh, ZQ-short and dummy-read request
//                generator feeding maint_handler.
//  Revision    : 1.0 - initial release
// ============================================================================
module maint_req_gen #(
    parameter int TIMER_WIDTH  = maint_pkg::TIMER_WIDTH,
    parameter int MAX_PEND_REF = maint_pkg::MAX_PEND_REF,
    parameter int PEND_WIDTH   = maint_pkg::PEND_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   autoref_en_i,
    input  logic [TIMER_WIDTH-1:0] autoref_interval_i,
    input  logic                   zq_en_i,
    input  logic [TIMER_WIDTH-1:0] zq_interval_i,
    input  logic                   pr_rd_en_i,
    input  logic [TIMER_WIDTH-1:0] pr_rd_interval_i,
    input  logic                   autoref_ack_i,
    input  logic                   zq_ack_i,
    input  logic                   pr_rd_ack_i,
    output logic                   autoref_req_o,
    output logic                   zq_req_o,
    output logic                   pr_rd_req_o,
    output logic [PEND_WIDTH-1:0]  autoref_pending_o,
    output logic                   autoref_urgent_o,
    output logic                   autoref_overflow_o
);

    import maint_pkg::*;

    localparam logic [PEND_WIDTH-1:0] C_PEND_FULL = PEND_WIDTH'(MAX_PEND_REF);

    logic w_ref_tick;
    logic w_zq_tick;
    logic w_pr_tick;

    maint_interval_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_ref_timer (
        .clk        (clk),
        .rst        (rst),
        .en_i       (autoref_en_i),
        .interval_i (autoref_interval_i),
        .tick_o     (w_ref_tick)
    );

    maint_interval_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_zq_timer (
        .clk        (clk),
        .rst        (rst),
        .en_i       (zq_en_i),
        .interval_i (zq_interval_i),
        .tick_o     (w_zq_tick)
    );

    maint_interval_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_pr_timer (
        .clk        (clk),
        .rst        (rst),
        .en_i       (pr_rd_en_i),
        .interval_i (pr_rd_interval_i),
        .tick_o     (w_pr_tick)
    );

    ref_op_e               w_ref_op;
    logic [PEND_WIDTH-1:0] pend_q,   pend_d;
    logic                  ovf_q,    ovf_d;
    logic                  ref_req_q;
    logic                  urgent_q;
    logic                  zq_q,     zq_d;
    logic                  pr_q,     pr_d;

    // A coincident tick and ack cancel, so overflow can only come from a lone tick.
    always_comb begin
        w_ref_op = REF_HOLD;
        ovf_d    = ovf_q;
        if (!autoref_en_i) begin
            w_ref_op = REF_CLR;
        end else if (w_ref_tick && !autoref_ack_i) begin
            if (pend_q == C_PEND_FULL) begin
                ovf_d = 1'b1;
            end else begin
                w_ref_op = REF_INC;
            end
        end else if (!w_ref_tick && autoref_ack_i && (pend_q != '0)) begin
            w_ref_op = REF_DEC;
        end
    end

    always_comb begin
        pend_d = pend_q;
        case (w_ref_op)
            REF_INC:  pend_d = pend_q + PEND_WIDTH'(1);
            REF_DEC:  pend_d = pend_q - PEND_WIDTH'(1);
            REF_CLR:  pend_d = '0;
            default:  pend_d = pend_q;
        endcase
    end

    // A fresh tick outranks an ack landing in the same cycle.
    always_comb begin
        zq_d = zq_en_i && (w_zq_tick || (zq_q && !zq_ack_i));
        pr_d = pr_rd_en_i && (w_pr_tick || (pr_q && !pr_rd_ack_i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= '0;
            ovf_q     <= 1'b0;
            ref_req_q <= 1'b0;
            urgent_q  <= 1'b0;
            zq_q      <= 1'b0;
            pr_q      <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            ref_req_q <= (pend_d != '0);
            urgent_q  <= (pend_d == C_PEND_FULL);
            zq_q      <= zq_d;
            pr_q      <= pr_d;
        end
    end

    assign autoref_req_o      = ref_req_q;
    assign autoref_pending_o  = pend_q;
    assign autoref_urgent_o   = urgent_q;
    assign autoref_overflow_o = ovf_q;
    assign zq_req_o           = zq_q;
    assign pr_rd_req_o        = pr_q;

endmodule
`default_nettype wire
